// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states,
// requester identifiers and the alignment rule shared by the datapath.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RMW_WR = 2'b10
    } state_e;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // True when the low address bits do not suit the access size, or the
    // size code itself is illegal.
    function automatic logic bad_align(input logic [1:0] lo, input logic [1:0] sz);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request/handshake on one
// side, completion pulse with extended load data and error on the other.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, uns, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, uns, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_lsu_align.sv
// Combinational lane logic: extracts and extends load data, merges sub-word
// store data into the current memory word, and flags illegal accesses.
module lsu_align
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_word_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_word_o,
    output logic        err_o
);
    localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half lanes of the read word.
    always_comb begin
        byte_s = rd_word_i[7:0];
        case (addr_i[1:0])
            2'd0:    byte_s = rd_word_i[7:0];
            2'd1:    byte_s = rd_word_i[15:8];
            2'd2:    byte_s = rd_word_i[23:16];
            2'd3:    byte_s = rd_word_i[31:24];
            default: byte_s = rd_word_i[7:0];
        endcase
        if (addr_i[1]) begin
            half_s = rd_word_i[31:16];
        end else begin
            half_s = rd_word_i[15:0];
        end
    end

    // Zero- or sign-extend the selected lane to a full word.
    always_comb begin
        load_data_o = 32'h0000_0000;
        case (size_i)
            SZ_B: begin
                if (uns_i) begin
                    load_data_o = {24'h00_0000, byte_s};
                end else begin
                    load_data_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_H: begin
                if (uns_i) begin
                    load_data_o = {16'h0000, half_s};
                end else begin
                    load_data_o = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_W:    load_data_o = rd_word_i;
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane; every other bit of the word survives.
    always_comb begin
        merge_word_o = rd_word_i;
        case (size_i)
            SZ_B: begin
                case (addr_i[1:0])
                    2'd0:    merge_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_word_o[23:16] = wdata_i[7:0];
                    2'd3:    merge_word_o[31:24] = wdata_i[7:0];
                    default: merge_word_o        = rd_word_i;
                endcase
            end
            SZ_H: begin
                if (addr_i[1]) begin
                    merge_word_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_word_o[15:0]  = wdata_i[15:0];
                end
            end
            default: merge_word_o = rd_word_i;
        endcase
    end

    // Misaligned, illegal size, or beyond the end of memory.
    always_comb begin
        err_o = bad_align(addr_i[1:0], size_i) || (addr_i >= LIMIT);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory.
// A granted request is latched, performed in ACCESS (plus RMW_WR for
// sub-word stores) and completed with a registered rvalid pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic [31:0]   A_mem,
    output logic [31:0]   DataIP,
    output logic          MemRW,
    input  logic [31:0]   D_read
);
    localparam int AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic        rr_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        id_q;
    logic [31:0] merge_q;
    logic        rvalid0_q, rvalid1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        any_req_s;
    logic        win_id_s;
    logic        gnt0_s, gnt1_s;
    logic        finish_s;
    logic        merge_ld_s;
    logic [31:0] word_idx_s;
    logic [31:0] load_data_s;
    logic [31:0] merge_word_s;
    logic        acc_err_s;
    logic        sel_we_s, sel_uns_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [1:0]  sel_size_s;

    assign word_idx_s = {{(32-AW){1'b0}}, addr_q[AW+1:2]};

    lsu_align #(.DEPTH(DEPTH)) u_align (
        .addr_i       (addr_q),
        .size_i       (size_q),
        .uns_i        (uns_q),
        .wdata_i      (wdata_q),
        .rd_word_i    (D_read),
        .load_data_o  (load_data_s),
        .merge_word_o (merge_word_s),
        .err_o        (acc_err_s)
    );

    // Arbitration: on a tie the round-robin pointer decides, else the sole requester wins.
    always_comb begin
        any_req_s = m0.req | m1.req;
        if (m0.req && m1.req) begin
            win_id_s = rr_q;
        end else if (m1.req) begin
            win_id_s = ID_M1;
        end else begin
            win_id_s = ID_M0;
        end
        if (win_id_s == ID_M1) begin
            sel_we_s    = m1.we;
            sel_uns_s   = m1.uns;
            sel_addr_s  = m1.addr;
            sel_size_s  = m1.size;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_we_s    = m0.we;
            sel_uns_s   = m0.uns;
            sel_addr_s  = m0.addr;
            sel_size_s  = m0.size;
            sel_wdata_s = m0.wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: only valid sub-word stores take the extra write cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!acc_err_s && we_q && (size_q != SZ_W)) begin
                    state_d = ST_RMW_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RMW_WR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grants, memory bus and completion strobe; all held low in reset.
    always_comb begin
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        MemRW      = 1'b0;
        A_mem      = 32'h0000_0000;
        DataIP     = 32'h0000_0000;
        finish_s   = 1'b0;
        merge_ld_s = 1'b0;
        if (rst) begin
            finish_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt0_s = (win_id_s == ID_M0);
                        gnt1_s = (win_id_s == ID_M1);
                    end else begin
                        gnt0_s = 1'b0;
                        gnt1_s = 1'b0;
                    end
                end
                ST_ACCESS: begin
                    A_mem = word_idx_s;
                    if (acc_err_s || !we_q) begin
                        finish_s = 1'b1;
                    end else if (size_q == SZ_W) begin
                        MemRW    = 1'b1;
                        DataIP   = wdata_q;
                        finish_s = 1'b1;
                    end else begin
                        merge_ld_s = 1'b1;
                    end
                end
                ST_RMW_WR: begin
                    A_mem    = word_idx_s;
                    MemRW    = 1'b1;
                    DataIP   = merge_q;
                    finish_s = 1'b1;
                end
                default: finish_s = 1'b0;
            endcase
        end
    end

    // Request latch, round-robin pointer, merge register and registered completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= ID_M0;
            addr_q    <= 32'h0000_0000;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= 32'h0000_0000;
            id_q      <= ID_M0;
            merge_q   <= 32'h0000_0000;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'h0000_0000;
            rdata1_q  <= 32'h0000_0000;
        end else begin
            if (gnt0_s || gnt1_s) begin
                addr_q  <= sel_addr_s;
                size_q  <= sel_size_s;
                we_q    <= sel_we_s;
                uns_q   <= sel_uns_s;
                wdata_q <= sel_wdata_s;
                id_q    <= win_id_s;
                rr_q    <= ~win_id_s;
            end
            if (merge_ld_s) begin
                merge_q <= merge_word_s;
            end
            rvalid0_q <= finish_s && (id_q == ID_M0);
            rvalid1_q <= finish_s && (id_q == ID_M1);
            err0_q    <= finish_s && (id_q == ID_M0) && acc_err_s;
            err1_q    <= finish_s && (id_q == ID_M1) && acc_err_s;
            rdata0_q  <= (finish_s && (id_q == ID_M0) && !acc_err_s && !we_q) ? load_data_s : 32'h0000_0000;
            rdata1_q  <= (finish_s && (id_q == ID_M1) && !acc_err_s && !we_q) ? load_data_s : 32'h0000_0000;
        end
    end

    assign m0.gnt    = gnt0_s;
    assign m1.gnt    = gnt1_s;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
    assign m0.err    = err0_q;
    assign m1.err    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] A_mem;
    logic [31:0] DataIP;
    logic        MemRW;
    logic [31:0] D_read;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter #(.DEPTH(1024)) dut (
        .clk    (clk),
        .rst    (rst),
        .m0     (m0_if.slave),
        .m1     (m1_if.slave),
        .A_mem  (A_mem),
        .DataIP (DataIP),
        .MemRW  (MemRW),
        .D_read (D_read)
    );

    logic [31:0] mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_val;
    int          wr_cnt = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign D_read = mem[A_mem[9:0]];

    // Behavioural memory: bench preload port, else DUT write on MemRW.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_val;
        end else if (MemRW) begin
            mem[A_mem[9:0]] <= DataIP;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] idx, input logic [31:0] val);
        ld_idx = idx;
        ld_val = val;
        ld_en  = 1'b1;
        tick();
        ld_en  = 1'b0;
    endtask

    task automatic drive(input bit id, input bit req, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wd);
        if (id) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr;
            m1_if.size = size; m1_if.uns = uns; m1_if.wdata = wd;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr;
            m0_if.size = size; m0_if.uns = uns; m0_if.wdata = wd;
        end
    endtask

    function automatic logic get_gnt(input bit id);
        return id ? m1_if.gnt : m0_if.gnt;
    endfunction

    function automatic logic get_rvalid(input bit id);
        return id ? m1_if.rvalid : m0_if.rvalid;
    endfunction

    // One complete transaction; lat counts cycles from the grant cycle to rvalid.
    task automatic run(input bit id, input bit we, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        drive(id, 1'b1, we, addr, size, uns, wd);
        #1;
        while (!get_gnt(id) && n < 20) begin
            tick();
            n++;
        end
        chk("gnt_seen", 32'(get_gnt(id)), 32'h1);
        tick();
        drive(id, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        lat = 1;
        while (!get_rvalid(id) && lat < 20) begin
            tick();
            lat++;
        end
        chk("rvalid_seen", 32'(get_rvalid(id)), 32'h1);
        rd = id ? m1_if.rdata : m0_if.rdata;
        er = id ? m1_if.err : m0_if.err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        int          k;
        int          both;
        int          seq [6];

        rst   = 1'b1;
        ld_en = 1'b0;
        ld_idx = 10'd0;
        ld_val = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        poke(10'd4, 32'h8899_AABB);
        poke(10'd1023, 32'h7F00_0001);

        // Reset: even with a request present nothing is granted or driven.
        drive(1'b0, 1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        #1;
        chk("rst_gnt0", 32'(m0_if.gnt), 32'h0);
        chk("rst_memrw", 32'(MemRW), 32'h0);
        chk("rst_amem", A_mem, 32'h0);
        chk("rst_dataip", DataIP, 32'h0);
        chk("rst_rvalid0", 32'(m0_if.rvalid), 32'h0);
        chk("rst_rdata1", m1_if.rdata, 32'h0);
        chk("rst_err1", 32'(m1_if.err), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Word and sub-word loads with extension.
        run(1'b0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, rd, er, lat);
        chk("t1_rdata", rd, 32'h8899_AABB);
        chk("t1_err", 32'(er), 32'h0);
        chk("t1_lat", 32'(lat), 32'd2);
        run(1'b0, 1'b0, 32'h13, SZ_B, 1'b0, 32'h0, rd, er, lat);
        chk("lb_13_s", rd, 32'hFFFF_FF88);
        run(1'b0, 1'b0, 32'h13, SZ_B, 1'b1, 32'h0, rd, er, lat);
        chk("lbu_13", rd, 32'h0000_0088);
        run(1'b0, 1'b0, 32'h12, SZ_H, 1'b0, 32'h0, rd, er, lat);
        chk("lh_12_s", rd, 32'hFFFF_8899);
        run(1'b1, 1'b0, 32'h10, SZ_B, 1'b0, 32'h0, rd, er, lat);
        chk("lb_10_s", rd, 32'hFFFF_FFBB);
        run(1'b1, 1'b0, 32'h10, SZ_H, 1'b1, 32'h0, rd, er, lat);
        chk("lhu_10", rd, 32'h0000_AABB);

        // Sub-word store: read-modify-write with exactly one write cycle.
        w0 = wr_cnt;
        run(1'b1, 1'b1, 32'h11, SZ_B, 1'b0, 32'h0000_005C, rd, er, lat);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_err", 32'(er), 32'h0);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb_word4", mem[4], 32'h8899_5CBB);
        run(1'b1, 1'b0, 32'h11, SZ_B, 1'b1, 32'h0, rd, er, lat);
        chk("lbu_11", rd, 32'h0000_005C);

        // Word store then half store into the same word.
        run(1'b0, 1'b1, 32'h20, SZ_W, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_word8", mem[8], 32'hDEAD_BEEF);
        run(1'b1, 1'b1, 32'h22, SZ_H, 1'b0, 32'hFFFF_1234, rd, er, lat);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_word8", mem[8], 32'h1234_BEEF);
        run(1'b0, 1'b0, 32'h20, SZ_H, 1'b0, 32'h0, rd, er, lat);
        chk("lh_20_s", rd, 32'hFFFF_BEEF);

        // Top of memory is still in range.
        run(1'b0, 1'b0, 32'hFFF, SZ_B, 1'b0, 32'h0, rd, er, lat);
        chk("lb_fff", rd, 32'h0000_007F);
        chk("lb_fff_err", 32'(er), 32'h0);
        run(1'b1, 1'b0, 32'hFFC, SZ_W, 1'b0, 32'h0, rd, er, lat);
        chk("lw_ffc", rd, 32'h7F00_0001);

        // Error cases: no memory write, err with zero data at +2.
        w0 = wr_cnt;
        run(1'b0, 1'b1, 32'h0E, SZ_W, 1'b0, 32'h1234_5678, rd, er, lat);
        chk("e_sw_err", 32'(er), 32'h1);
        chk("e_sw_lat", 32'(lat), 32'd2);
        run(1'b0, 1'b0, 32'h11, SZ_H, 1'b0, 32'h0, rd, er, lat);
        chk("e_lh_err", 32'(er), 32'h1);
        chk("e_lh_rdata", rd, 32'h0);
        run(1'b1, 1'b0, 32'h1000, SZ_W, 1'b0, 32'h0, rd, er, lat);
        chk("e_oor_err", 32'(er), 32'h1);
        chk("e_oor_rdata", rd, 32'h0);
        chk("e_oor_lat", 32'(lat), 32'd2);
        run(1'b1, 1'b1, 32'h1000, SZ_B, 1'b0, 32'hA5, rd, er, lat);
        chk("e_oor_sb_err", 32'(er), 32'h1);
        chk("e_oor_sb_lat", 32'(lat), 32'd2);
        run(1'b0, 1'b0, 32'h10, SZ_X, 1'b0, 32'h0, rd, er, lat);
        chk("e_sz_err", 32'(er), 32'h1);
        chk("e_writes", 32'(wr_cnt - w0), 32'd0);

        // Continuous contention from a fresh reset: grants alternate m0,m1,...
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        #1;
        k = 0;
        both = 0;
        for (int c = 0; c < 12; c++) begin
            if (m0_if.gnt && m1_if.gnt) both++;
            if ((m0_if.gnt || m1_if.gnt) && k < 6) begin
                seq[k] = m1_if.gnt ? 1 : 0;
                k++;
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        chk("rr_both", 32'(both), 32'd0);
        chk("rr_count", 32'(k), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(i % 2));
        end
        tick();
        tick();
        tick();

        // Reset during RMW_WR: the write is suppressed and outputs clear.
        w0 = wr_cnt;
        drive(1'b1, 1'b1, 1'b1, 32'h12, SZ_B, 1'b0, 32'h0000_00A5);
        #1;
        k = 0;
        while (!m1_if.gnt && k < 20) begin
            tick();
            k++;
        end
        chk("r6_gnt", 32'(m1_if.gnt), 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
        chk("r6_access_memrw", 32'(MemRW), 32'h0);
        tick();
        chk("r6_rmw_memrw", 32'(MemRW), 32'h1);
        rst = 1'b1;
        #1;
        chk("r6_gated_memrw", 32'(MemRW), 32'h0);
        tick();
        chk("r6_rvalid1", 32'(m1_if.rvalid), 32'h0);
        chk("r6_err1", 32'(m1_if.err), 32'h0);
        chk("r6_rdata1", m1_if.rdata, 32'h0);
        chk("r6_amem", A_mem, 32'h0);
        chk("r6_dataip", DataIP, 32'h0);
        chk("r6_writes", 32'(wr_cnt - w0), 32'd0);
        chk("r6_word4", mem[4], 32'h8899_5CBB);
        rst = 1'b0;
        tick();
        run(1'b0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, rd, er, lat);
        chk("r6_reload", rd, 32'h8899_5CBB);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
